// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter that serialises single read/write commands
// from NUM_REQ requesters onto one APB master port, with an optional ACCESS
// timeout that completes the command with an error flag.

package apb_pkg;
    parameter int unsigned ADDR_WIDTH = 32;
    parameter int unsigned DATA_WIDTH = 32;
endpackage

module apb_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = apb_pkg::DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PWRITE,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int unsigned IDXW    = $clog2(NUM_REQ);
    localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDXW-1:0]         r_last;
    logic [CW-1:0]           r_cnt;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic                    r_pwrite;
    logic                    r_psel;
    logic                    r_penable;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    logic                    w_found;
    logic [IDXW-1:0]         w_gnt;
    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic [NUM_REQ-1:0]      w_last_oh;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_write;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_abort;

    // Round-robin pick: first pass looks above the last grant, second pass wraps to the bottom.
    always_comb begin
        w_found  = 1'b0;
        w_gnt    = '0;
        w_gnt_oh = '0;
        w_addr   = '0;
        w_wdata  = '0;
        w_write  = 1'b0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] &&
                    ((p == 0) ? (IDXW'(i) > r_last) : (IDXW'(i) <= r_last))) begin
                    w_found     = 1'b1;
                    w_gnt       = IDXW'(i);
                    w_gnt_oh[i] = 1'b1;
                    w_addr      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    w_wdata     = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    w_write     = req_write[i];
                end
            end
        end
    end

    // Next-state logic and transfer strobes for the APB phase sequencer.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if ((TIMEOUT != 0) && (r_cnt == CW'(TO_LAST))) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // APB outputs, wait counter, grant history and the one-cycle response pulse.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_last      <= IDXW'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_paddr   <= w_addr;
                r_pwrite  <= w_write;
                r_pwdata  <= w_wdata;
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_last    <= w_gnt;
            end
            if (r_state == SETUP) begin
                r_penable <= 1'b1;
                r_cnt     <= '0;
            end
            if ((r_state == ACCESS) && !w_done && !w_abort) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done || w_abort) begin
                r_psel      <= 1'b0;
                r_penable   <= 1'b0;
                r_rsp_valid <= w_last_oh;
                r_rsp_err   <= w_abort;
            end
            if (w_done && !r_pwrite) begin
                r_rsp_rdata <= PRDATA;
            end
        end
    end

    assign w_last_oh = NUM_REQ'(1) << r_last;
    assign req_ready = (r_state == IDLE) ? w_gnt_oh : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWDATA    = r_pwdata;

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin arbiter and APB sequencer that shares one APB master port among NUM_REQ internal requesters. Each requester issues single read/write commands over a valid/ready handshake. The block serialises the commands into compliant SETUP/ACCESS transfers toward the dual-port memory slave and returns the read data, or a timeout error, to the originating requester.

## Interface
- NUM_REQ, 2: number of requesters (≥2)
- ADDR_WIDTH, apb_pkg::ADDR_WIDTH: PADDR width
- DATA_WIDTH, apb_pkg::DATA_WIDTH: PWDATA/PRDATA width
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  combinational accept, one-hot or zero
- rsp_valid  out  NUM_REQ  registered one-cycle completion pulse, one-hot or zero
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- rsp_err  out  1  timeout flag, qualified by any rsp_valid bit
- PADDR  out  ADDR_WIDTH
- PWRITE  out  1
- PSEL  out  1
- PENABLE  out  1
- PWDATA  out  DATA_WIDTH
- PRDATA  in  DATA_WIDTH
- PREADY  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any req_valid is set, the grant g is the first set bit searching from (last+1) mod NUM_REQ, with wrap-around.
  - req_ready[g]=1 combinationally in this cycle. This is the accept.
  - At the edge: PADDR/PWRITE/PWDATA load from requester g, PSEL←1, PENABLE←0, last←g, state→SETUP.
  - With no req_valid: no outputs change except the rsp_valid clear.
- **SETUP:** PENABLE←1, state→ACCESS, wait counter←0. PREADY is ignored in SETUP.
- **ACCESS:**
  - PREADY=1: PSEL←0, PENABLE←0, rsp_valid[g]←1, rsp_err←0. For a read, rsp_rdata←PRDATA; for a write, rsp_rdata holds its value. State→IDLE.
  - PREADY=0 and TIMEOUT≠0 and counter==TIMEOUT-1: abort. PSEL←0, PENABLE←0, rsp_valid[g]←1, rsp_err←1, rsp_data unchanged, state→IDLE.
  - Otherwise counter increments. PADDR/PWRITE/PWDATA/PSEL/PENABLE stay stable.
- req_ready is 0 in SETUP and ACCESS. Requesters hold their command stable until accepted.
- A requester deasserting req_valid before accept is legal; its command is simply not issued.
- rsp_valid is high exactly one cycle per accepted command, and is cleared in every cycle it was not just set.
- PADDR/PWRITE/PWDATA hold their last values when PSEL=0.
- Reset values: state IDLE, last=NUM_REQ-1 (requester 0 wins first), PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset mid-transfer: the transfer is abandoned. PSEL/PENABLE are 0 in the cycle after reset is sampled, and no rsp_valid is produced for it.

## Timing
- Zero-wait transfer:
  - Cycle 0: IDLE, req_ready[g]=1.
  - Cycle 1: PSEL=1, PENABLE=0.
  - Cycle 2: PSEL=1, PENABLE=1, PREADY=1 sampled.
  - Cycle 3: PSEL=0, rsp_valid[g]=1, rsp_rdata valid. The FSM is in IDLE, so a new accept is possible in cycle 3.
- Peak throughput is one transfer per 3 cycles. Each PREADY=0 cycle in ACCESS adds one cycle.
- Timeout: with TIMEOUT=T and PREADY held low, ACCESS lasts exactly T cycles. rsp_err=1 appears in the following cycle.
- Grant is decided only in IDLE. Requests arriving during a transfer wait; they are not queued.

## Test plan
- **Single write then read, zero-wait:**
  - Stimulus: requester 0 writes 0xA5A5_0001 to addr 0x10, then reads addr 0x10 with the slave returning 0xA5A5_0001.
  - Expect: PSEL rises 1 cycle after accept, PENABLE 1 cycle later. rsp_valid[0] pulses in cycle 3 of each transfer. Read rsp_rdata=0xA5A5_0001 and rsp_err=0.
- **Round-robin fairness:**
  - Stimulus: NUM_REQ=2, both req_valid held high for 4 commands each.
  - Expect: grant order 0,1,0,1,… and APB transfers back-to-back every 3 cycles.
- **Wait states:**
  - Stimulus: slave holds PREADY=0 for 3 ACCESS cycles.
  - Expect: PADDR/PWDATA/PSEL/PENABLE stable throughout, rsp_valid 6 cycles after accept, rsp_err=0.
- **Timeout:**
  - Stimulus: TIMEOUT=4, PREADY stuck at 0.
  - Expect: PSEL drops after 4 ACCESS cycles, rsp_valid=1 with rsp_err=1, rsp_rdata unchanged from its prior value. The next request is served normally.
- **Reset mid-ACCESS:**
  - Stimulus: PRESETn=0 for one cycle during ACCESS.
  - Expect: all outputs at reset values the next cycle and no rsp_valid. After reset, requester 0 wins when both request.
- **Withdrawn request:**
  - Stimulus: requester 1 pulses req_valid for one cycle while a transfer is in flight.
  - Expect: no transfer is issued for requester 1.
